// File: rtl/pcie_crdt_pkg.sv
// rtl/pcie_crdt_pkg.sv - shared types, widths and helpers for the CRDT_DOWN credit generator
package pcie_crdt_pkg;

  typedef enum logic [1:0] {
    CRDT_P    = 2'd0,
    CRDT_NP   = 2'd1,
    CRDT_CPL  = 2'd2,
    CRDT_RSVD = 2'd3
  } crdt_type_e;

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_DONE_PEND = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam int UPD_PH   = 5;
  localparam int UPD_NPH  = 4;
  localparam int UPD_CPLH = 3;
  localparam int UPD_PD   = 2;
  localparam int UPD_NPD  = 1;
  localparam int UPD_CPLD = 0;

  localparam int HDR_CNT_W  = 2;
  localparam int DATA_CNT_W = 4;
  localparam int HDR_MAX    = 3;
  localparam int DATA_MAX   = 15;

  localparam int DW_W     = 11;
  localparam int CRDT_W   = 10;
  localparam int INFLOW_W = 12;

  // One data credit covers 4 DW; partial groups round up.
  function automatic logic [CRDT_W-1:0] dw2crdt(input logic [DW_W-1:0] dw);
    logic [DW_W:0] t;
    t = {1'b0, dw} + (DW_W+1)'(3);
    return t[DW_W:2];
  endfunction

endpackage

// File: rtl/pcie_crdt_down_gen_if.sv
// rtl/pcie_crdt_down_gen_if.sv - consumption events in, CRDT_DOWN credit updates out
interface pcie_crdt_down_gen_if #(
  parameter int REGIONS = 4
);
  import pcie_crdt_pkg::*;

  logic [REGIONS-1:0]      CONS_VLD;
  logic [REGIONS*2-1:0]    CONS_TYPE;
  logic [REGIONS*DW_W-1:0] CONS_DW;

  logic                  CRDT_DOWN_INIT_DONE;
  logic [5:0]            CRDT_DOWN_UPDATE;
  logic [HDR_CNT_W-1:0]  CRDT_DOWN_CNT_PH;
  logic [HDR_CNT_W-1:0]  CRDT_DOWN_CNT_NPH;
  logic [HDR_CNT_W-1:0]  CRDT_DOWN_CNT_CPLH;
  logic [DATA_CNT_W-1:0] CRDT_DOWN_CNT_PD;
  logic [DATA_CNT_W-1:0] CRDT_DOWN_CNT_NPD;
  logic [DATA_CNT_W-1:0] CRDT_DOWN_CNT_CPLD;
  logic                  ACC_OVF;

  modport master (
    output CONS_VLD, CONS_TYPE, CONS_DW,
    input  CRDT_DOWN_INIT_DONE, CRDT_DOWN_UPDATE,
    input  CRDT_DOWN_CNT_PH, CRDT_DOWN_CNT_NPH, CRDT_DOWN_CNT_CPLH,
    input  CRDT_DOWN_CNT_PD, CRDT_DOWN_CNT_NPD, CRDT_DOWN_CNT_CPLD,
    input  ACC_OVF
  );

  modport slave (
    input  CONS_VLD, CONS_TYPE, CONS_DW,
    output CRDT_DOWN_INIT_DONE, CRDT_DOWN_UPDATE,
    output CRDT_DOWN_CNT_PH, CRDT_DOWN_CNT_NPH, CRDT_DOWN_CNT_CPLH,
    output CRDT_DOWN_CNT_PD, CRDT_DOWN_CNT_NPD, CRDT_DOWN_CNT_CPLD,
    output ACC_OVF
  );

endinterface

// File: rtl/pcie_crdt_chan.sv
// rtl/pcie_crdt_chan.sv - one credit channel: preloaded accumulator, min-emit, saturating inflow
module pcie_crdt_chan
  import pcie_crdt_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int INIT      = 0,
  parameter int CNT_W     = 2,
  parameter int CNT_MAX   = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INFLOW_W-1:0] inflow_i,
  output logic [CNT_W-1:0]    emit_o,
  output logic                ovf_o,
  output logic                idle_o
);

  localparam int SUM_W = ((ACC_WIDTH > INFLOW_W) ? ACC_WIDTH : INFLOW_W) + 1;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    emit_o = '0;
    if (SUM_W'(acc_q) >= SUM_W'(CNT_MAX)) begin
      emit_o = CNT_W'(CNT_MAX);
    end else begin
      emit_o = acc_q[CNT_W-1:0];
    end
    // Emission and inflow land in the same cycle; the wide sum cannot wrap.
    sum    = SUM_W'(acc_q) - SUM_W'(emit_o) + SUM_W'(inflow_i);
    ovf_o  = |sum[SUM_W-1:ACC_WIDTH];
    acc_d  = ovf_o ? '1 : sum[ACC_WIDTH-1:0];
    idle_o = (acc_q == '0) && (acc_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= ACC_WIDTH'(INIT);
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pcie_crdt_down_gen.sv
// rtl/pcie_crdt_down_gen.sv - R-Tile CRDT_DOWN generator: init advertisement then CQ/RC credit returns
module pcie_crdt_down_gen
  import pcie_crdt_pkg::*;
#(
  parameter int REGIONS   = 4,
  parameter int INIT_PH   = 64,
  parameter int INIT_NPH  = 64,
  parameter int INIT_CPLH = 256,
  parameter int INIT_PD   = 1024,
  parameter int INIT_NPD  = 16,
  parameter int INIT_CPLD = 1024,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 PCIE_CLK,
  input  logic                 PCIE_RESET,
  pcie_crdt_down_gen_if.slave  crdt_if
);

  localparam int HDR_INIT  [3] = '{INIT_PH, INIT_NPH, INIT_CPLH};
  localparam int DATA_INIT [3] = '{INIT_PD, INIT_NPD, INIT_CPLD};

  logic [INFLOW_W-1:0]   hdr_in    [3];
  logic [INFLOW_W-1:0]   data_in   [3];
  logic [HDR_CNT_W-1:0]  hdr_emit  [3];
  logic [DATA_CNT_W-1:0] data_emit [3];
  logic [CRDT_W-1:0]     credits;
  logic                  rsvd_seen;
  logic [5:0]            chan_ovf;
  logic [5:0]            chan_idle;

  state_e                state_q, state_d;
  logic                  init_done_q;
  logic [5:0]            update_q, update_d;
  logic [HDR_CNT_W-1:0]  hdr_cnt_q  [3];
  logic [DATA_CNT_W-1:0] data_cnt_q [3];
  logic                  acc_ovf_q;

  // Index t follows the credit type encoding: 0=P, 1=NP, 2=CPL.
  always_comb begin
    for (int t = 0; t < 3; t++) begin
      hdr_in[t]  = '0;
      data_in[t] = '0;
    end
    rsvd_seen = 1'b0;
    credits   = '0;
    for (int r = 0; r < REGIONS; r++) begin
      if (crdt_if.CONS_VLD[r]) begin
        credits = dw2crdt(crdt_if.CONS_DW[r*DW_W +: DW_W]);
        if (crdt_if.CONS_TYPE[r*2 +: 2] == CRDT_RSVD) begin
          rsvd_seen = 1'b1;
        end
        for (int t = 0; t < 3; t++) begin
          if (crdt_if.CONS_TYPE[r*2 +: 2] == 2'(t)) begin
            hdr_in[t]  = hdr_in[t] + INFLOW_W'(1);
            data_in[t] = data_in[t] + INFLOW_W'(credits);
          end
        end
      end
    end
  end

  for (genvar t = 0; t < 3; t++) begin : g_chan
    pcie_crdt_chan #(
      .ACC_WIDTH (ACC_WIDTH),
      .INIT      (HDR_INIT[t]),
      .CNT_W     (HDR_CNT_W),
      .CNT_MAX   (HDR_MAX)
    ) u_hdr (
      .clk_i    (PCIE_CLK),
      .rst_i    (PCIE_RESET),
      .inflow_i (hdr_in[t]),
      .emit_o   (hdr_emit[t]),
      .ovf_o    (chan_ovf[UPD_PH-t]),
      .idle_o   (chan_idle[UPD_PH-t])
    );

    pcie_crdt_chan #(
      .ACC_WIDTH (ACC_WIDTH),
      .INIT      (DATA_INIT[t]),
      .CNT_W     (DATA_CNT_W),
      .CNT_MAX   (DATA_MAX)
    ) u_data (
      .clk_i    (PCIE_CLK),
      .rst_i    (PCIE_RESET),
      .inflow_i (data_in[t]),
      .emit_o   (data_emit[t]),
      .ovf_o    (chan_ovf[UPD_PD-t]),
      .idle_o   (chan_idle[UPD_PD-t])
    );
  end

  always_comb begin
    update_d = '0;
    for (int t = 0; t < 3; t++) begin
      update_d[UPD_PH-t] = |hdr_emit[t];
      update_d[UPD_PD-t] = |data_emit[t];
    end
  end

  // INIT only completes once nothing is left and nothing new arrived this cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:      if (&chan_idle) state_d = ST_DONE_PEND;
      ST_DONE_PEND: state_d = ST_RUN;
      ST_RUN:       state_d = ST_RUN;
      default:      state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge PCIE_CLK) begin
    if (PCIE_RESET) begin
      state_q     <= ST_INIT;
      init_done_q <= 1'b0;
      update_q    <= '0;
      acc_ovf_q   <= 1'b0;
      for (int t = 0; t < 3; t++) begin
        hdr_cnt_q[t]  <= '0;
        data_cnt_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == ST_RUN);
      update_q    <= update_d;
      acc_ovf_q   <= acc_ovf_q | (|chan_ovf) | rsvd_seen;
      for (int t = 0; t < 3; t++) begin
        hdr_cnt_q[t]  <= hdr_emit[t];
        data_cnt_q[t] <= data_emit[t];
      end
    end
  end

  assign crdt_if.CRDT_DOWN_INIT_DONE = init_done_q;
  assign crdt_if.CRDT_DOWN_UPDATE    = update_q;
  assign crdt_if.CRDT_DOWN_CNT_PH    = hdr_cnt_q[0];
  assign crdt_if.CRDT_DOWN_CNT_NPH   = hdr_cnt_q[1];
  assign crdt_if.CRDT_DOWN_CNT_CPLH  = hdr_cnt_q[2];
  assign crdt_if.CRDT_DOWN_CNT_PD    = data_cnt_q[0];
  assign crdt_if.CRDT_DOWN_CNT_NPD   = data_cnt_q[1];
  assign crdt_if.CRDT_DOWN_CNT_CPLD  = data_cnt_q[2];
  assign crdt_if.ACC_OVF             = acc_ovf_q;

endmodule
